// File: rtl/if_fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch front end.
// A fetched entry pairs the PC with the instruction word the ROM returned for it.
package if_fetch_unit_pkg;

  localparam int unsigned INST_ADDR_W = 32;
  localparam int unsigned INST_W      = 32;

  localparam logic [INST_W-1:0]      ZERO_WORD        = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic                   RST_ENABLE       = 1'b1;
  localparam logic                   CHIP_ENABLE      = 1'b1;
  localparam logic                   CHIP_DISABLE     = 1'b0;

  typedef logic [INST_ADDR_W-1:0] inst_addr_t;
  typedef logic [INST_W-1:0]      inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  // The ROM is word-indexed, so redirect targets drop their byte offset.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return {addr[INST_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_fetch_unit_fetch_fifo.sv
// Prefetch FIFO of {pc, inst} entries: registered storage, head readable with no latency.
// Clear has priority over push/pop; DEPTH must be a power of two so pointers wrap for free.
module fetch_fifo
  import if_fetch_unit_pkg::*;
#(
  parameter  int unsigned DEPTH = 2,
  localparam int unsigned PTR_W = $clog2(DEPTH),
  localparam int unsigned CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic             clear_i,
  input  fetch_entry_t     wdata_i,
  output fetch_entry_t     head_o,
  output logic [CNT_W-1:0] count_o,
  output logic             full_o,
  output logic             empty_o
);

  fetch_entry_t     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push_i && !pop_i)      count_d = count_q + CNT_W'(1);
      else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; empty slots are never presented.
  always_ff @(posedge clk) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch front end: drives the ROM, buffers {pc, inst} in a prefetch FIFO
// and hands entries to decode over valid/ready; flush and branch redirect the PC.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush_i,
  input  logic [31:0] new_pc_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_addr_i,
  output logic        rom_ce_o,
  output logic [31:0] rom_addr_o,
  input  logic [31:0] rom_inst_i,
  output logic        id_valid_o,
  input  logic        id_ready_i,
  output logic [31:0] id_pc_o,
  output logic [31:0] id_inst_o
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  inst_addr_t       pc_q, pc_d;
  logic             ce_q;
  logic             redirect_c, push_c, pop_c;
  fetch_entry_t     head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full, fifo_empty;

  assign redirect_c = flush_i | branch_flag_i;
  assign pop_c      = ~fifo_empty & id_ready_i;
  // A full FIFO still accepts a word when decode drains the head in the same cycle.
  assign push_c     = ce_q & ~redirect_c & (~fifo_full | pop_c);

  always_comb begin
    pc_d = pc_q;
    if (flush_i)            pc_d = align_word(new_pc_i);
    else if (branch_flag_i) pc_d = align_word(branch_target_addr_i);
    else if (push_c)        pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pc_q <= RESET_PC;
      ce_q <= CHIP_DISABLE;
    end else begin
      pc_q <= pc_d;
      ce_q <= CHIP_ENABLE;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push_c),
    .pop_i   (pop_c),
    .clear_i (redirect_c),
    .wdata_i ('{pc: pc_q, inst: rom_inst_i}),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign rom_ce_o   = ce_q;
  assign rom_addr_o = ce_q ? pc_q : ZERO_WORD;
  assign id_valid_o = (fifo_count != CNT_W'(0));
  assign id_pc_o    = id_valid_o ? head.pc   : ZERO_WORD;
  assign id_inst_o  = id_valid_o ? head.inst : ZERO_WORD;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: per-cycle vector table plus an in-order scoreboard of
// every {pc, inst} handed to decode; a mid-stream reset is run by hand.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] new_pc;
  logic        br_flag;
  logic [31:0] br_tgt;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_inst;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_pc;
  logic [31:0] id_inst;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic        flush;
    logic [31:0] npc;
    logic        br;
    logic [31:0] tgt;
    logic        rdy;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } sb_t;

  vec_t vecs[25];
  sb_t  sb_q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h1000_0000 + {2'b00, a[31:2]};
  endfunction

  assign rom_inst = rom_ce ? rom_word(rom_addr) : 32'h0;

  if_fetch_unit dut (
    .clk                  (clk),
    .rst                  (rst),
    .flush_i              (flush),
    .new_pc_i             (new_pc),
    .branch_flag_i        (br_flag),
    .branch_target_addr_i (br_tgt),
    .rom_ce_o             (rom_ce),
    .rom_addr_o           (rom_addr),
    .rom_inst_i           (rom_inst),
    .id_valid_o           (id_valid),
    .id_ready_i           (id_ready),
    .id_pc_o              (id_pc),
    .id_inst_o            (id_inst)
  );

  function automatic vec_t mk(input logic f, input logic [31:0] np, input logic b,
                              input logic [31:0] t, input logic r, input logic ce,
                              input logic [31:0] ad, input logic v, input logic [31:0] p);
    vec_t x;
    x.flush = f; x.npc = np; x.br = b; x.tgt = t; x.rdy = r;
    x.ce = ce; x.addr = ad; x.valid = v; x.pc = p;
    return x;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted handshake must match the next expected entry.
  always @(negedge clk) begin
    if (rst === 1'b0 && id_valid === 1'b1 && id_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL sb_unexpected: got pc %h, expected no handshake", id_pc);
      end else begin
        sb_t e;
        e = sb_q.pop_front();
        check("sb_pc", id_pc, e.pc);
        check("sb_inst", id_inst, e.inst);
      end
    end
  end

  task automatic drive_idle();
    flush = 1'b0; new_pc = 32'h0; br_flag = 1'b0; br_tgt = 32'h0; id_ready = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Entered #1 after a posedge; checks the cycle mid-way, leaves #1 after the next posedge.
  task automatic apply_vec(input int i);
    vec_t v;
    sb_t  e;
    v = vecs[i];
    flush = v.flush; new_pc = v.npc; br_flag = v.br; br_tgt = v.tgt; id_ready = v.rdy;
    if (v.rdy && v.valid) begin
      e.pc = v.pc;
      e.inst = rom_word(v.pc);
      sb_q.push_back(e);
    end
    @(negedge clk);
    check($sformatf("v%0d_ce", i),    {31'b0, rom_ce},   {31'b0, v.ce});
    check($sformatf("v%0d_addr", i),  rom_addr,          v.addr);
    check($sformatf("v%0d_valid", i), {31'b0, id_valid}, {31'b0, v.valid});
    check($sformatf("v%0d_pc", i),    id_pc,             v.valid ? v.pc : 32'h0);
    check($sformatf("v%0d_inst", i),  id_inst,           v.valid ? rom_word(v.pc) : 32'h0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    //                flush npc           br  tgt           rdy  ce  addr          vld pc
    vecs[0]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b0, 32'h0,        1'b0, 32'h0);
    vecs[1]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h0,        1'b0, 32'h0);
    vecs[2]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h4,        1'b1, 32'h0);
    vecs[3]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h8,        1'b1, 32'h4);
    vecs[4]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'hC,        1'b1, 32'h8);
    vecs[5]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h10,       1'b1, 32'h8);
    vecs[6]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h10,       1'b1, 32'h8);
    vecs[7]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h10,       1'b1, 32'h8);
    vecs[8]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h10,       1'b1, 32'h8);
    vecs[9]  = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h10,       1'b1, 32'h8);
    vecs[10] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h14,       1'b1, 32'hC);
    vecs[11] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h18,       1'b1, 32'h10);
    vecs[12] = mk(1'b0, 32'h0,        1'b1, 32'h103,  1'b0, 1'b1, 32'h18,       1'b1, 32'h10);
    vecs[13] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h100,      1'b0, 32'h0);
    vecs[14] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h104,      1'b1, 32'h100);
    vecs[15] = mk(1'b1, 32'h40,       1'b1, 32'h80,   1'b1, 1'b1, 32'h108,      1'b1, 32'h104);
    vecs[16] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h40,       1'b0, 32'h0);
    vecs[17] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h44,       1'b1, 32'h40);
    vecs[18] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h48,       1'b1, 32'h44);
    vecs[19] = mk(1'b1, 32'hFFFF_FFFF, 1'b0, 32'h0,   1'b1, 1'b1, 32'h4C,       1'b1, 32'h48);
    vecs[20] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
    vecs[21] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h0,        1'b1, 32'hFFFF_FFFC);
    vecs[22] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b1, 1'b1, 32'h4,        1'b1, 32'h0);
    vecs[23] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'h8,        1'b1, 32'h4);
    vecs[24] = mk(1'b0, 32'h0,        1'b0, 32'h0,    1'b0, 1'b1, 32'hC,        1'b1, 32'h4);

    do_reset();
    for (int i = 0; i < 25; i++) apply_vec(i);

    // Reset while the FIFO is full and decode is stalled.
    drive_idle();
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ce",    {31'b0, rom_ce},   32'h0);
    check("rst_addr",  rom_addr,          32'h0);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_pc",    id_pc,             32'h0);
    check("rst_inst",  id_inst,           32'h0);
    @(posedge clk);
    #1;
    // Restart from RESET_PC; vector 0 re-checks the post-reset cycle just seen.
    for (int i = 1; i < 4; i++) apply_vec(i);

    drive_idle();
    @(negedge clk);
    check("sb_drained", sb_q.size(), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the RV32I SoPC. Sits directly upstream of the instruction ROM and drives its chip-enable and byte address.
- Captures the returned instruction word, paired with its PC, into a small prefetch FIFO.
- Presents entries to the decode-stage register through a valid/ready handshake.
- Absorbs decode back-pressure without losing fetched words. Handles branch redirects and pipeline flushes from execute and ctrl.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.
- FIFO_DEPTH, 2, prefetch entries. Must be a power of two, at least 2.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- flush_i  in  1  pipeline flush from ctrl
- new_pc_i  in  32  restart PC when flush_i=1
- branch_flag_i  in  1  taken branch/jump from execute
- branch_target_addr_i  in  32  branch target
- rom_ce_o  out  1  ROM chip enable, to ROM ce
- rom_addr_o  out  32  ROM byte address, to ROM addr
- rom_inst_i  in  32  ROM instruction word, combinational, same cycle
- id_valid_o  out  1  FIFO head valid
- id_ready_i  in  1  decode accepts the head this cycle
- id_pc_o  out  32  head PC
- id_inst_o  out  32  head instruction

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - pc <= RESET_PC, ce_r <= 0, FIFO count <= 0, head/tail pointers <= 0.
  - Outputs: rom_ce_o=0, rom_addr_o=0, id_valid_o=0, id_pc_o=0, id_inst_o=0.
- First edge with rst=0: ce_r <= 1. Fetch of RESET_PC happens in the following cycle.
- rom_ce_o = ce_r.
- rom_addr_o = pc when ce_r=1, else 0. The ROM is word-indexed by addr[..:2], so pc[1:0] is always 0.
- pop = id_valid_o & id_ready_i.
- redirect = flush_i | branch_flag_i.
- push = ce_r & ~redirect & ((count < FIFO_DEPTH) | pop).
  - Full FIFO with a simultaneous pop: push is allowed.
  - Full FIFO without a pop: no push, pc holds, rom_addr_o is unchanged.
- On push:
  - The entry {pc, rom_inst_i} is written at the tail.
  - pc <= pc + 4, mod 2^32: 32'hFFFF_FFFC wraps to 0.
- Redirect priority: flush_i over branch_flag_i.
  - pc <= {new_pc_i[31:2], 2'b00} on flush, or {branch_target_addr_i[31:2], 2'b00} on branch. Misaligned low bits are silently cleared.
  - FIFO cleared (count=0) on the same edge. Any simultaneous pop is still consumed by decode; nothing is pushed in that cycle.
  - The first word from the new PC is fetched in the next cycle and appears at id_* one cycle after that. Redirect-to-decode latency is 2 cycles.
- Fetch latency: the word fetched in cycle n is at the FIFO head, registered, visible in cycle n+1 when the FIFO was empty.
- Throughput: 1 instruction/cycle sustained while id_ready_i=1.
- id_valid_o = (count != 0).
- id_pc_o and id_inst_o show the head entry when valid, else 0 (ZeroWord).
- count update:
  - redirect → 0
  - push & ~pop → +1
  - pop & ~push → −1
  - otherwise hold
- Pointers wrap modulo FIFO_DEPTH.
- rst asserted mid-stream: all state returns to reset values on that edge. In-flight entries are discarded.

Decomposition:
- define.v supplies ZeroWord, RstEnable, ChipEnable/ChipDisable, InstAddrBus, InstBus, and RESET_PC's default value.
- One sub-module, fetch_fifo: parameterised synchronous FIFO of {pc, inst} entries.
  - Inputs: push, pop, clear.
  - Outputs: head data, count, full, empty.
  - A registered storage array only, no read latency on the head.
- The PC register, ce_r and the redirect logic stay in if_fetch_unit.

Test Plan:
- Reset release, ROM preloaded with inst = 0x1000_0000 + index, id_ready_i=1 → rom_ce_o=0 for 1 cycle, then rom_addr_o = 0,4,8,…. id_valid_o rises 2 cycles after rst falls with id_pc_o=0, id_inst_o=0x1000_0000, then one new entry per cycle.
- Hold id_ready_i=0 for 5 cycles from steady state → after 2 pushes the FIFO is full, rom_addr_o is frozen at the 3rd PC, and id_pc_o stays on the first entry. On release, entries drain in order with no PC skipped or duplicated.
- branch_flag_i=1, branch_target_addr_i=0x0000_0103 while the FIFO holds 2 entries → next cycle id_valid_o=0 and rom_addr_o=0x100. The following cycle id_pc_o=0x100.
- flush_i=1 with new_pc_i=0x40 and branch_flag_i=1 with target 0x80 in the same cycle → fetch resumes at 0x40; 0x80 is never fetched.
- Force pc to 32'hFFFF_FFFC via flush → the next fetch address is 0x0000_0000.
- Assert rst for 1 cycle while id_ready_i=0 and the FIFO is full → all outputs are 0 in the next cycle, and the fetch sequence restarts at RESET_PC as in test 1.
